// File: rtl/fetch_line_ctrl.sv
// fetch_line_ctrl: holds one instruction line, serves hits and runs one refill at a time
module fetch_line_ctrl #(
   parameter int XLEN          = 32,
   parameter int ILEN          = 32,
   parameter int OFFSET        = 2,
   parameter int ICACHE_OFFSET = 2,
   parameter int LINE_W        = ILEN * (2 ** ICACHE_OFFSET)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              pc_valid_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic              flush_i,
   input  logic              here_i,
   input  logic              will_be_here_i,
   output logic [XLEN-1:0]   line_pc_o,
   output logic              line_valid_o,
   output logic [XLEN-1:0]   prev_pc_o,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic [XLEN-1:0]   req_addr_o,
   input  logic              resp_valid_i,
   input  logic [LINE_W-1:0] resp_line_i,
   output logic              instr_valid_o,
   output logic [ILEN-1:0]   instr_o,
   output logic              busy_o
);
   localparam int AW = ICACHE_OFFSET + OFFSET;
   localparam logic [XLEN-1:0] MASK = ~((XLEN'(1) << AW) - XLEN'(1));
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
   state_t state, state_n;
   logic [XLEN-1:0] pend_pc;
   logic [LINE_W-1:0] line_q;
   logic abort, abort_n, start, fill;
   logic unused;
   assign unused = will_be_here_i;
   assign prev_pc_o = pend_pc;
   assign req_addr_o = pend_pc;
   assign req_valid_o = state == REQ;
   assign busy_o = state != IDLE;
   assign instr_valid_o = rst_n_i & pc_valid_i & here_i & ~flush_i;
   assign instr_o = line_q[ILEN*int'(pc_i[AW-1:OFFSET]) +: ILEN];
   // next-state, abort tracking and line-fill decision
   always_comb begin
      state_n = state;
      abort_n = 1'b0;
      start = 1'b0;
      fill = 1'b0;
      case (state)
         IDLE: if (pc_valid_i && !here_i && !flush_i) begin
            state_n = REQ;
            start = 1'b1;
         end
         REQ: begin
            abort_n = abort | flush_i;
            if (req_ready_i) begin
               state_n = (abort || flush_i) ? DRAIN : WAIT;
               abort_n = 1'b0;
            end
         end
         WAIT: if (resp_valid_i) begin
            state_n = IDLE;
            fill = !flush_i;
         end else if (flush_i) state_n = DRAIN;
         DRAIN: if (resp_valid_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state, pending address and held line registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         abort <= 1'b0;
         pend_pc <= '0;
         line_pc_o <= '0;
         line_q <= '0;
         line_valid_o <= 1'b0;
      end else begin
         state <= state_n;
         abort <= abort_n;
         if (start) pend_pc <= pc_i & MASK;
         if (fill) begin
            line_q <= resp_line_i;
            line_pc_o <= pend_pc;
         end
         line_valid_o <= flush_i ? 1'b0 : (fill | line_valid_o);
      end
   end
endmodule

// File: tb/tb_fetch_line_ctrl.sv
// tb_fetch_line_ctrl: directed checks of hits, refills, stalls, flushes and reset
module tb_fetch_line_ctrl;
   logic clk = 0, rst_n = 0, pc_valid = 0, flush = 0, here_force = 0;
   logic req_ready = 0, resp_valid = 0;
   logic [31:0] pc = 0;
   logic [127:0] resp_line = 0;
   logic [31:0] line_pc, prev_pc, req_addr, instr;
   logic line_valid, req_valid, instr_valid, busy, here, will_be_here;
   int checks = 0, errors = 0;
   logic [31:0] words [4] = '{32'h88887777, 32'h66665555, 32'h22221111, 32'h44443333};
   always #5 clk = ~clk;
   // presence checker model built from the fed-back line/pending addresses
   assign here = here_force | (line_valid && (pc & ~32'hF) == line_pc);
   assign will_be_here = busy && (pc & ~32'hF) == prev_pc;
   fetch_line_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n), .pc_valid_i(pc_valid), .pc_i(pc), .flush_i(flush),
      .here_i(here), .will_be_here_i(will_be_here), .line_pc_o(line_pc),
      .line_valid_o(line_valid), .prev_pc_o(prev_pc), .req_valid_o(req_valid),
      .req_ready_i(req_ready), .req_addr_o(req_addr), .resp_valid_i(resp_valid),
      .resp_line_i(resp_line), .instr_valid_o(instr_valid), .instr_o(instr), .busy_o(busy)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask
   initial begin
      cyc();
      pc_valid = 1;
      here_force = 1;
      #1;
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_busy", busy, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_line_valid", line_valid, 0);
      check("rst_line_pc", line_pc, 0);
      check("rst_prev_pc", prev_pc, 0);
      here_force = 0;
      cyc();
      rst_n = 1;
      pc = 32'h100;
      #1;
      check("miss_c0_busy", busy, 0);
      check("miss_c0_instr_valid", instr_valid, 0);
      cyc();
      #1;
      check("miss_c1_req_valid", req_valid, 1);
      check("miss_c1_req_addr", req_addr, 32'h100);
      check("miss_c1_prev_pc", prev_pc, 32'h100);
      req_ready = 1;
      cyc();
      req_ready = 0;
      #1;
      check("miss_c2_req_valid", req_valid, 0);
      check("miss_c2_busy", busy, 1);
      resp_valid = 1;
      resp_line = 128'h44443333_22221111_66665555_88887777;
      cyc();
      resp_valid = 0;
      pc = 32'h108;
      #1;
      check("fill_line_pc", line_pc, 32'h100);
      check("fill_line_valid", line_valid, 1);
      check("fill_busy", busy, 0);
      check("fill_instr_valid", instr_valid, 1);
      check("fill_instr", instr, 32'h22221111);
      for (int i = 0; i < 4; i++) begin
         cyc();
         pc = 32'h100 + 32'(4 * i);
         #1;
         check("hit_instr_valid", instr_valid, 1);
         check("hit_instr", instr, words[i]);
         check("hit_req_valid", req_valid, 0);
      end
      cyc();
      pc = 32'h204;
      #1;
      check("stall_miss_instr_valid", instr_valid, 0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_req_valid", req_valid, 1);
         check("stall_req_addr", req_addr, 32'h200);
         cyc();
      end
      req_ready = 1;
      #1;
      check("stall_hs_req_valid", req_valid, 1);
      cyc();
      req_ready = 0;
      pc = 32'h300;
      #1;
      check("wait_req_valid", req_valid, 0);
      check("other_miss_instr_valid", instr_valid, 0);
      cyc();
      #1;
      check("other_miss_no_req", req_valid, 0);
      check("other_miss_prev_pc", prev_pc, 32'h200);
      check("other_miss_line_valid", line_valid, 1);
      flush = 1;
      pc_valid = 0;
      cyc();
      flush = 0;
      #1;
      check("drain_line_valid", line_valid, 0);
      check("drain_busy", busy, 1);
      cyc();
      cyc();
      cyc();
      resp_valid = 1;
      resp_line = {4{32'hDEADBEEF}};
      #1;
      check("drain_pre_resp_busy", busy, 1);
      cyc();
      resp_valid = 0;
      #1;
      check("drain_post_busy", busy, 0);
      check("drain_post_line_valid", line_valid, 0);
      pc = 32'h400;
      pc_valid = 1;
      cyc();
      pc_valid = 0;
      #1;
      check("reqflush_req_valid", req_valid, 1);
      flush = 1;
      cyc();
      flush = 0;
      #1;
      check("reqflush_held_req", req_valid, 1);
      check("reqflush_req_addr", req_addr, 32'h400);
      cyc();
      req_ready = 1;
      cyc();
      req_ready = 0;
      resp_valid = 1;
      #1;
      check("reqflush_busy", busy, 1);
      check("reqflush_req_dropped", req_valid, 0);
      cyc();
      resp_valid = 0;
      #1;
      check("reqflush_discard_valid", line_valid, 0);
      check("reqflush_idle", busy, 0);
      pc = 32'h500;
      pc_valid = 1;
      cyc();
      pc_valid = 0;
      req_ready = 1;
      cyc();
      req_ready = 0;
      flush = 1;
      resp_valid = 1;
      cyc();
      flush = 0;
      resp_valid = 0;
      #1;
      check("flushresp_busy", busy, 0);
      check("flushresp_line_valid", line_valid, 0);
      check("flushresp_line_kept", instr, 32'h88887777);
      check("flushresp_line_pc", line_pc, 32'h100);
      pc = 32'h600;
      pc_valid = 1;
      cyc();
      req_ready = 1;
      cyc();
      req_ready = 0;
      rst_n = 0;
      here_force = 1;
      #1;
      check("rstmid_busy_before", busy, 1);
      check("rstmid_instr_valid", instr_valid, 0);
      cyc();
      #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_req_valid", req_valid, 0);
      check("rstmid_line_valid", line_valid, 0);
      check("rstmid_line_pc", line_pc, 0);
      check("rstmid_prev_pc", prev_pc, 0);
      check("rstmid_instr", instr, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
